dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, SHALL set the word address width of the shared data memory.
REQ-002 Parameter STARVE_MAX, default 4, SHALL set the consecutive host-loss cycles after which the host is forced a grant.
REQ-003 Parameter LOCK_MAX, default 8, SHALL set the maximum consecutive beats the host may hold while locked.
REQ-004 Port clk  in  1: the single clock; all state updates on its rising edge.
REQ-005 Port nrst  in  1: reset, synchronous and active-low.
REQ-006 Ports core_req in 1, core_we in 4, core_addr in ADDR_W, core_wdata in 32: core request, byte-lane write enables, address and write data.
REQ-007 Ports core_gnt out 1, core_rvalid out 1, core_rdata out 32: core grant, read-data valid and read data.
REQ-008 Ports host_req in 1, host_lock in 1, host_we in 4, host_addr in ADDR_W, host_wdata in 32: host/debug request, lock, enables, address and data.
REQ-009 Ports host_gnt out 1, host_rvalid out 1, host_rdata out 32: host grant, read-data valid and read data.
REQ-010 Ports mem_we out 4, mem_addr out ADDR_W, mem_wdata out 32, mem_rdata in 32: the four byte-lane banks of data memory.

Function
REQ-011 Grant SHALL be combinational from the current requests and registered state; at most one of core_gnt/host_gnt SHALL be high in any cycle.
REQ-012 The granted requester's we/addr/wdata SHALL drive mem_we/mem_addr/mem_wdata in the grant cycle; with no grant mem_we SHALL be 4'b0000 and mem_addr all-zero.
REQ-013 A request SHALL be held, with stable signals, until granted; a beat completes in the cycle its gnt is high.
REQ-014 A granted beat with we==0 SHALL raise that requester's rvalid for exactly one cycle on the next cycle, with rdata equal to mem_rdata; the other requester's rdata SHALL be zero.
REQ-015 A granted beat with any we bit set SHALL write only the enabled lanes and SHALL NOT raise rvalid.
REQ-016 FSM states: ARB and HOST_LOCK.
REQ-017 ARB: the core wins simultaneous requests, unless the starvation counter equals STARVE_MAX, in which case the host wins.
REQ-018 Starvation counter: increments, saturating at STARVE_MAX, on each cycle host_req is high and host_gnt is low; clears on any host grant or when host_req is low.
REQ-019 ARB to HOST_LOCK: on a host grant with host_lock high; the beat counter loads 1.
REQ-020 HOST_LOCK: the host wins every cycle it requests; the beat counter increments on each host grant.
REQ-021 HOST_LOCK to ARB: when host_lock is low, or when host_req is low, or in the cycle after the beat counter reaches LOCK_MAX; the core then has priority for at least one cycle.
REQ-022 In HOST_LOCK with host_req low and core_req high, the core SHALL be granted in the same cycle as the exit.

Reset
REQ-023 While nrst is low at a rising clk edge: FSM to ARB, both counters to 0, core_rvalid/host_rvalid to 0.
REQ-024 During reset the grants and mem_we SHALL be 0 and all rdata outputs zero.
REQ-025 A read granted in the cycle before reset SHALL NOT produce rvalid after reset.

Structure
REQ-026 Package dmem_arb_pkg SHALL hold the FSM state type and the default values of ADDR_W, STARVE_MAX and LOCK_MAX.
REQ-027 One sub-module, arb_sat_counter (saturating up-counter with clear), SHALL be instantiated twice: once for starvation and once for lock beats.

Verification
REQ-028 Core and host request continuously, host_lock=0, STARVE_MAX=4 -> core granted 4 cycles, host granted on the 5th, then the pattern repeats.
REQ-029 Host read addr 6'h05 after a core write of 32'hDEADBEEF with we=4'b1111 to addr 6'h05 -> host_rvalid one cycle after host_gnt, host_rdata=32'hDEADBEEF, core_rvalid=0.
REQ-030 Core write with we=4'b0001 of 32'h000000AA to a word holding 32'h11223344, then a core read -> 32'h112233AA.
REQ-031 Host locked, requesting continuously, LOCK_MAX=8, core requesting -> host granted 8 consecutive beats, then core granted.
REQ-032 nrst low for one cycle directly after a granted core read -> no core_rvalid, FSM in ARB, next simultaneous request grants the core.
REQ-033 No requests for 10 cycles -> mem_we=0 and mem_addr=0 throughout; no rvalid.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
// Holds the arbiter FSM state type and the default values of the
// address width, host starvation limit and host lock beat limit.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W     = 6;
    localparam int DEF_STARVE_MAX = 4;
    localparam int DEF_LOCK_MAX   = 8;

    typedef enum logic [0:0] {
        ARB       = 1'b0,
        HOST_LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk     in  clock, rising edge
//   nrst    in  synchronous active-low reset (count to 0)
//   clr     in  clear; with inc also high the count loads 1
//   inc     in  increment, holds at MAX
//   at_max  out count equals MAX
module arb_sat_counter
    import dmem_arb_pkg::*;
#(
    parameter int MAX = DEF_STARVE_MAX,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    logic [W-1:0] cnt;

    assign at_max = (cnt == W'(MAX));

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (clr) begin
            // clear-and-count starts a fresh run at one
            cnt <= inc ? W'(1) : '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a shared, byte-lane data memory.
// The core normally has priority; the host is forced a grant after
// STARVE_MAX consecutive lost cycles and may lock the memory for up
// to LOCK_MAX consecutive beats. Reads return data one cycle after
// the grant, qualified by the requester's rvalid.
// Ports:
//   clk, nrst                         clock, synchronous active-low reset
//   core_req/we/addr/wdata            core request side
//   core_gnt/rvalid/rdata             core grant and read return
//   host_req/lock/we/addr/wdata       host/debug request side
//   host_gnt/rvalid/rdata             host grant and read return
//   mem_we/addr/wdata, mem_rdata      memory port (read data one cycle late)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX,
    parameter int LOCK_MAX   = DEF_LOCK_MAX
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              core_req,
    input  logic [3:0]        core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [31:0]       core_rdata,
    input  logic              host_req,
    input  logic              host_lock,
    input  logic [3:0]        host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [31:0]       host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [31:0]       host_rdata,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    arb_state_t state_q;
    arb_state_t state_d;

    logic starve_at_max;
    logic starve_clr;
    logic starve_inc;
    logic lock_at_max;
    logic lock_clr;
    logic lock_inc;
    logic core_rvalid_p1;
    logic host_rvalid_p1;

    arb_sat_counter #(.MAX(STARVE_MAX)) u_starve_cnt (
        .clk    (clk),
        .nrst   (nrst),
        .clr    (starve_clr),
        .inc    (starve_inc),
        .at_max (starve_at_max)
    );

    arb_sat_counter #(.MAX(LOCK_MAX)) u_lock_cnt (
        .clk    (clk),
        .nrst   (nrst),
        .clr    (lock_clr),
        .inc    (lock_inc),
        .at_max (lock_at_max)
    );

    // Grant and next-state decision. Grants are forced low while in reset.
    always_comb begin
        state_d  = state_q;
        core_gnt = 1'b0;
        host_gnt = 1'b0;
        lock_clr = 1'b1;
        lock_inc = 1'b0;
        if (nrst) begin
            unique case (state_q)
                ARB: begin
                    if (host_req && (!core_req || starve_at_max)) begin
                        host_gnt = 1'b1;
                    end else if (core_req) begin
                        core_gnt = 1'b1;
                    end
                    // clr together with inc loads the beat counter with 1
                    if (host_gnt && host_lock) begin
                        state_d  = HOST_LOCK;
                        lock_inc = 1'b1;
                    end
                end
                HOST_LOCK: begin
                    if (host_req && host_lock && !lock_at_max) begin
                        host_gnt = 1'b1;
                        lock_clr = 1'b0;
                        lock_inc = 1'b1;
                    end else begin
                        // exit cycle: core has priority and is served now
                        state_d = ARB;
                        if (core_req) begin
                            core_gnt = 1'b1;
                        end else if (host_req) begin
                            host_gnt = 1'b1;
                        end
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    assign starve_inc = host_req && !host_gnt;
    assign starve_clr = host_gnt || !host_req;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory port mux: idle port drives zero address and no write lanes.
    always_comb begin
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_gnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (host_gnt) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    // Read return: memory data arrives one cycle after a granted read
    always_ff @(posedge clk) begin
        if (!nrst) begin
            core_rvalid_p1 <= 1'b0;
            host_rvalid_p1 <= 1'b0;
        end else begin
            core_rvalid_p1 <= core_gnt && (core_we == 4'b0000);
            host_rvalid_p1 <= host_gnt && (host_we == 4'b0000);
        end
    end

    // Masking with nrst keeps a read issued just before reset from
    // surfacing while reset is asserted.
    assign core_rvalid = core_rvalid_p1 && nrst;
    assign host_rvalid = host_rvalid_p1 && nrst;
    assign core_rdata  = core_rvalid ? mem_rdata : 32'h0;
    assign host_rdata  = host_rvalid ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        nrst;
    logic        core_req;
    logic [3:0]  core_we;
    logic [5:0]  core_addr;
    logic [31:0] core_wdata;
    logic        core_gnt;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        host_req;
    logic        host_lock;
    logic [3:0]  host_we;
    logic [5:0]  host_addr;
    logic [31:0] host_wdata;
    logic        host_gnt;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic [3:0]  mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk         (clk),
        .nrst        (nrst),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .host_req    (host_req),
        .host_lock   (host_lock),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // byte-lane synchronous memory, read data one cycle after address
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_req = 1'b0; core_we = 4'h0; core_addr = 6'h0; core_wdata = 32'h0;
        host_req = 1'b0; host_lock = 1'b0; host_we = 4'h0; host_addr = 6'h0; host_wdata = 32'h0;
    endtask

    logic [1:0] exp_g;
    logic       exp_rv;

    initial begin
        idle_inputs();
        nrst = 1'b0;

        // reset with both requesting: nothing granted, no write, rdata zero
        core_req = 1'b1; core_we = 4'hF; host_req = 1'b1; host_we = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_gnt", {30'b0, core_gnt, host_gnt}, 32'h0);
            chk("rst_mem_we", {28'b0, mem_we}, 32'h0);
            chk("rst_rdata", core_rdata | host_rdata, 32'h0);
            chk("rst_rvalid", {30'b0, core_rvalid, host_rvalid}, 32'h0);
            tick();
        end

        // idle for 10 cycles: no write lanes, zero address, no rvalid
        idle_inputs();
        nrst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle", {24'b0, mem_we, mem_addr != 6'h0, core_rvalid, host_rvalid, core_gnt | host_gnt}, 32'h0);
            tick();
        end

        // core full write 11223344 to addr 3
        core_req = 1'b1; core_we = 4'hF; core_addr = 6'h03; core_wdata = 32'h11223344;
        @(negedge clk);
        chk("cw_gnt", {30'b0, core_gnt, host_gnt}, 32'h2);
        chk("cw_mem_we", {28'b0, mem_we}, 32'hF);
        chk("cw_mem_addr", {26'b0, mem_addr}, 32'h3);
        chk("cw_mem_wdata", mem_wdata, 32'h11223344);
        tick();
        // lane-0 write of AA
        core_we = 4'b0001; core_wdata = 32'h000000AA;
        @(negedge clk);
        chk("cw_lane_we", {28'b0, mem_we}, 32'h1);
        tick();
        chk("cw_no_rvalid", {31'b0, core_rvalid}, 32'h0);
        // core read addr 3
        core_we = 4'h0;
        @(negedge clk);
        chk("cr_gnt", {31'b0, core_gnt}, 32'h1);
        tick();
        core_req = 1'b0;
        @(negedge clk);
        chk("cr_rvalid", {30'b0, core_rvalid, host_rvalid}, 32'h2);
        chk("cr_rdata", core_rdata, 32'h112233AA);
        chk("cr_host_rdata", host_rdata, 32'h0);
        tick();
        @(negedge clk);
        chk("cr_rvalid_once", {31'b0, core_rvalid}, 32'h0);
        tick();

        // core writes DEADBEEF to 5, host reads it back
        core_req = 1'b1; core_we = 4'hF; core_addr = 6'h05; core_wdata = 32'hDEADBEEF;
        tick();
        core_req = 1'b0; core_we = 4'h0;
        host_req = 1'b1; host_we = 4'h0; host_addr = 6'h05;
        @(negedge clk);
        chk("hr_gnt", {30'b0, core_gnt, host_gnt}, 32'h1);
        chk("hr_mem_addr", {26'b0, mem_addr}, 32'h5);
        tick();
        host_req = 1'b0;
        @(negedge clk);
        chk("hr_rvalid", {30'b0, core_rvalid, host_rvalid}, 32'h1);
        chk("hr_rdata", host_rdata, 32'hDEADBEEF);
        chk("hr_core_rdata", core_rdata, 32'h0);
        tick();

        // starvation: core 4 cycles, host on the 5th, repeating
        core_req = 1'b1; core_addr = 6'h01; host_req = 1'b1; host_addr = 6'h02;
        exp_rv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_g = ((i % 5) == 4) ? 2'b01 : 2'b10;
            @(negedge clk);
            chk($sformatf("starve_gnt_%0d", i), {30'b0, core_gnt, host_gnt}, {30'b0, exp_g});
            chk($sformatf("starve_crv_%0d", i), {31'b0, core_rvalid}, {31'b0, exp_rv});
            exp_rv = exp_g[1];
            tick();
        end
        idle_inputs();
        tick();

        // lock: host first beat alone, then core competes; 8 host beats then core
        host_req = 1'b1; host_lock = 1'b1; host_addr = 6'h02;
        for (int i = 0; i < 10; i++) begin
            if (i == 1) core_req = 1'b1;
            exp_g = (i < 8) ? 2'b01 : 2'b10;
            @(negedge clk);
            chk($sformatf("lock_gnt_%0d", i), {30'b0, core_gnt, host_gnt}, {30'b0, exp_g});
            tick();
        end
        idle_inputs();
        tick();

        // lock exit by host_req low: core granted in the exit cycle
        host_req = 1'b1; host_lock = 1'b1;
        @(negedge clk);
        chk("lx_host_gnt", {30'b0, core_gnt, host_gnt}, 32'h1);
        tick();
        host_req = 1'b0; core_req = 1'b1;
        @(negedge clk);
        chk("lx_core_gnt", {30'b0, core_gnt, host_gnt}, 32'h2);
        tick();
        idle_inputs();
        tick();

        // reset directly after a granted core read
        core_req = 1'b1; core_we = 4'h0; core_addr = 6'h03;
        @(negedge clk);
        chk("pr_gnt", {31'b0, core_gnt}, 32'h1);
        tick();
        nrst = 1'b0; host_req = 1'b1;
        @(negedge clk);
        chk("pr_rst_rvalid", {31'b0, core_rvalid}, 32'h0);
        chk("pr_rst_rdata", core_rdata, 32'h0);
        chk("pr_rst_gnt", {30'b0, core_gnt, host_gnt}, 32'h0);
        tick();
        nrst = 1'b1;
        @(negedge clk);
        chk("pr_after_rvalid", {31'b0, core_rvalid}, 32'h0);
        chk("pr_after_gnt", {30'b0, core_gnt, host_gnt}, 32'h2);
        tick();
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
